// File: rtl/csr_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : csr_register_bank
//  Brief    : Responder end of the CSR strobe bus. One register slot per
//             strobe line; slots are either read/write control words or
//             write-one-to-clear sticky status words. All slots are
//             presented continuously on a registered, concatenated
//             readback bus.
//  Revision : 1.0  initial release
// ============================================================================
module csr_register_bank #(
  parameter int                                  CSR_DATA_BUS_WIDTH   = 32,
  parameter int                                  CSR_STROBE_BUS_WIDTH = 8,
  parameter logic [CSR_STROBE_BUS_WIDTH-1:0]     CTRL_MASK            = 8'h0F,
  parameter logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [CSR_STROBE_BUS_WIDTH-1:0]                   csr_stb_i,
  input  logic [CSR_DATA_BUS_WIDTH-1:0]                     csr_data_i,
  output logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] csr_data_o,
  output logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] ctrl_o,
  output logic [CSR_STROBE_BUS_WIDTH-1:0]                   wr_pulse_o,
  input  logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] status_i,
  output logic [15:0]                                       err_cnt_o
);

  localparam int DW = CSR_DATA_BUS_WIDTH;
  localparam int NREG = CSR_STROBE_BUS_WIDTH;
  localparam int BUSW = NREG * DW;
  localparam logic [15:0] C_ERR_MAX = 16'hFFFF;

  // Expand the per-slot control mask into a per-bit mask over the whole bus.
  function automatic logic [BUSW-1:0] expand_mask(input logic [NREG-1:0] m);
    logic [BUSW-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) begin
      if (m[i]) r[i*DW +: DW] = {DW{1'b1}};
    end
    return r;
  endfunction

  localparam logic [BUSW-1:0] C_CTRL_BITS = expand_mask(CTRL_MASK);
  localparam logic [BUSW-1:0] C_RESET_VAL = CTRL_RESET & C_CTRL_BITS;

  // One flat register array: control slots hold the control word,
  // status slots hold the sticky bits.
  logic [BUSW-1:0] regs_q, regs_d;
  logic [BUSW-1:0] rdata_q, rdata_d;
  logic [NREG-1:0] stb_prev_q, stb_prev_d;
  logic [NREG-1:0] wr_pulse_q, wr_pulse_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            wr_event;
  logic            wr_onehot;
  logic            wr_accept;

  // A write event is a rising edge on the strobe bus as a whole; only a
  // one-hot event is a legal write.
  always_comb begin
    wr_event  = (csr_stb_i != '0) && (stb_prev_q == '0);
    wr_onehot = $onehot(csr_stb_i);
    wr_accept = wr_event && wr_onehot;
  end

  // Next-state for slots: control writes load data, status slots accumulate
  // status_i and clear on written ones, with set taking priority.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG; i++) begin
      if (CTRL_MASK[i]) begin
        if (wr_accept && csr_stb_i[i]) regs_d[i*DW +: DW] = csr_data_i;
      end else if (wr_accept && csr_stb_i[i]) begin
        regs_d[i*DW +: DW] = (regs_q[i*DW +: DW] & ~csr_data_i) | status_i[i*DW +: DW];
      end else begin
        regs_d[i*DW +: DW] = regs_q[i*DW +: DW] | status_i[i*DW +: DW];
      end
    end
  end

  // Strobe history, write pulses, readback pipeline and saturating error count.
  always_comb begin
    stb_prev_d = csr_stb_i;
    wr_pulse_d = wr_accept ? csr_stb_i : '0;
    rdata_d    = regs_q;
    err_cnt_d  = err_cnt_q;
    if (wr_event && !wr_onehot && (err_cnt_q != C_ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= C_RESET_VAL;
      rdata_q    <= C_RESET_VAL;
      stb_prev_q <= '0;
      wr_pulse_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      rdata_q    <= rdata_d;
      stb_prev_q <= stb_prev_d;
      wr_pulse_q <= wr_pulse_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Control view is combinational from the registers; status slots read zero.
  always_comb begin
    ctrl_o     = regs_q & C_CTRL_BITS;
    csr_data_o = rdata_q;
    wr_pulse_o = wr_pulse_q;
    err_cnt_o  = err_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_register_bank
//  Brief    : Self-checking bench for csr_register_bank: table-driven single
//             writes plus hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_register_bank;

  localparam int DW = 32;
  localparam int NREG = 8;
  localparam int BUSW = DW * NREG;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREG-1:0] csr_stb_i;
  logic [DW-1:0]   csr_data_i;
  logic [BUSW-1:0] csr_data_o;
  logic [BUSW-1:0] ctrl_o;
  logic [NREG-1:0] wr_pulse_o;
  logic [BUSW-1:0] status_i;
  logic [15:0]     err_cnt_o;

  int errors = 0;
  int checks = 0;

  csr_register_bank #(
    .CSR_DATA_BUS_WIDTH  (DW),
    .CSR_STROBE_BUS_WIDTH(NREG),
    .CTRL_MASK           (8'h0F),
    .CTRL_RESET          ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr_stb_i (csr_stb_i),
    .csr_data_i(csr_data_i),
    .csr_data_o(csr_data_o),
    .ctrl_o    (ctrl_o),
    .wr_pulse_o(wr_pulse_o),
    .status_i  (status_i),
    .err_cnt_o (err_cnt_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  stb;
    logic [31:0] data;
    logic [7:0]  exp_pulse;
    logic [15:0] exp_err;
    int          slot;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] model[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_of(input logic [BUSW-1:0] bus, input int s);
    return bus[s*DW +: DW];
  endfunction

  task automatic write32(input int sel, input logic [31:0] d);
    csr_stb_i  = 8'(1 << sel);
    csr_data_i = d;
    tick();
    csr_stb_i  = '0;
    tick();
  endtask

  task automatic multi_hot_event();
    csr_stb_i  = 8'h11;
    csr_data_i = 32'd123;
    tick();
    csr_stb_i  = '0;
    tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int sel;
    logic [31:0] d;

    vecs[0] = '{8'h04, 32'd777,        8'h04, 16'd0, 2, 32'd777};
    vecs[1] = '{8'h01, 32'd5,          8'h01, 16'd0, 0, 32'd5};
    vecs[2] = '{8'h11, 32'd123,        8'h00, 16'd1, 0, 32'd5};
    vecs[3] = '{8'h20, 32'd0,          8'h20, 16'd1, 5, 32'd0};
    vecs[4] = '{8'h08, 32'hDEAD_BEEF,  8'h08, 16'd1, 3, 32'hDEAD_BEEF};
    vecs[5] = '{8'h03, 32'd1,          8'h00, 16'd2, 1, 32'd0};
    vecs[6] = '{8'h80, 32'hFFFF_FFFF,  8'h80, 16'd2, 7, 32'd0};
    vecs[7] = '{8'h02, 32'h1234_5678,  8'h02, 16'd2, 1, 32'h1234_5678};

    rst_n      = 1'b0;
    csr_stb_i  = '0;
    csr_data_i = '0;
    status_i   = '0;
    repeat (2) tick();
    chk("reset_rdata", csr_data_o, '0);
    chk("reset_ctrl", ctrl_o, '0);
    chk("reset_pulse", BUSW'(wr_pulse_o), '0);
    chk("reset_err", BUSW'(err_cnt_o), '0);
    rst_n = 1'b1;
    tick();

    // Table-driven single writes
    for (int i = 0; i < 8; i++) begin
      csr_stb_i  = vecs[i].stb;
      csr_data_i = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_pulse", i), BUSW'(wr_pulse_o), BUSW'(vecs[i].exp_pulse));
      chk($sformatf("vec%0d_err", i), BUSW'(err_cnt_o), BUSW'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ctrl", i), BUSW'(slot_of(ctrl_o, vecs[i].slot)),
          BUSW'((vecs[i].slot < 4) ? vecs[i].exp_val : 32'd0));
      csr_stb_i = '0;
      tick();
      chk($sformatf("vec%0d_pulse_off", i), BUSW'(wr_pulse_o), '0);
      chk($sformatf("vec%0d_rdata", i), BUSW'(slot_of(csr_data_o, vecs[i].slot)),
          BUSW'(vecs[i].exp_val));
    end
    chk("table_slot2_kept", BUSW'(slot_of(csr_data_o, 2)), BUSW'(32'd777));

    // Held strobe: one write only, later data ignored
    pulses     = 0;
    csr_stb_i  = 8'h01;
    csr_data_i = 32'd6;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) csr_data_i = 32'd9;
      tick();
      if (wr_pulse_o != '0) pulses++;
    end
    csr_stb_i = '0;
    tick();
    if (wr_pulse_o != '0) pulses++;
    tick();
    chk("hold_pulses", BUSW'(pulses), BUSW'(1));
    chk("hold_ctrl", BUSW'(slot_of(ctrl_o, 0)), BUSW'(32'd6));
    chk("hold_rdata", BUSW'(slot_of(csr_data_o, 0)), BUSW'(32'd6));

    // Sticky status on slot 5
    status_i[5*DW +: DW] = 32'h3;
    tick();
    status_i = '0;
    tick();
    tick();
    chk("sticky_set", BUSW'(slot_of(csr_data_o, 5)), BUSW'(32'h3));
    write32(5, 32'd1);
    tick();
    chk("sticky_w1c", BUSW'(slot_of(csr_data_o, 5)), BUSW'(32'h2));
    status_i[5*DW +: DW] = 32'h1;
    csr_stb_i  = 8'h20;
    csr_data_i = 32'd3;
    tick();
    status_i  = '0;
    csr_stb_i = '0;
    tick();
    tick();
    chk("sticky_set_wins", BUSW'(slot_of(csr_data_o, 5)), BUSW'(32'h1));
    chk("sticky_ctrl_untouched", ctrl_o,
        {128'd0, 32'hDEAD_BEEF, 32'd777, 32'h1234_5678, 32'd6});

    // Error counter increment and saturation
    multi_hot_event();
    chk("err_inc", BUSW'(err_cnt_o), BUSW'(16'd3));
    chk("err_no_change_s0", BUSW'(slot_of(csr_data_o, 0)), BUSW'(32'd6));
    chk("err_no_change_s4", BUSW'(slot_of(csr_data_o, 4)), BUSW'(32'd0));
    force dut.err_cnt_q = 16'hFFFD;
    tick();
    release dut.err_cnt_q;
    tick();
    multi_hot_event();
    chk("err_near_max", BUSW'(err_cnt_o), BUSW'(16'hFFFE));
    for (int k = 0; k < 3; k++) multi_hot_event();
    chk("err_saturate", BUSW'(err_cnt_o), BUSW'(16'hFFFF));

    // Random write/read sequence over control slots
    for (int s = 0; s < 4; s++) model[s] = slot_of(ctrl_o, s);
    for (int n = 0; n < 10; n++) begin
      sel = int'($urandom_range(0, 3));
      d   = $urandom;
      write32(sel, d);
      model[sel] = d;
      sel = int'($urandom_range(0, 3));
      chk($sformatf("rand%0d_read32_s%0d", n, sel), BUSW'(slot_of(csr_data_o, sel)), BUSW'(model[sel]));
    end

    // Reset mid-write with strobe held through deassertion
    csr_stb_i  = 8'h04;
    csr_data_i = 32'd99;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rdata", csr_data_o, '0);
    chk("midreset_ctrl", ctrl_o, '0);
    chk("midreset_err", BUSW'(err_cnt_o), '0);
    chk("midreset_pulse", BUSW'(wr_pulse_o), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_pulse", BUSW'(wr_pulse_o), BUSW'(8'h04));
    chk("post_reset_ctrl", BUSW'(slot_of(ctrl_o, 2)), BUSW'(32'd99));
    csr_stb_i = '0;
    tick();
    chk("post_reset_rdata", BUSW'(slot_of(csr_data_o, 2)), BUSW'(32'd99));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
